// File: rtl/fetch_queue_if.sv
// Fetch front-end bus bundle: instruction-memory request/response plus decode-side FIFO head.
interface fetch_queue_if #(
    parameter int unsigned PC_WIDTH = 8,
    parameter int unsigned DEPTH    = 4
);
    logic                       redirect;
    logic [PC_WIDTH-1:0]        redirect_pc;
    logic                       imem_req;
    logic [PC_WIDTH-1:0]        imem_addr;
    logic                       imem_gnt;
    logic                       imem_rvalid;
    logic [31:0]                imem_rdata;
    logic                       inst_valid;
    logic [31:0]                inst;
    logic [PC_WIDTH-1:0]        inst_pc;
    logic                       inst_ready;
    logic [$clog2(DEPTH):0]     count;

    // Fetch unit side
    modport master (
        input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        output imem_req, imem_addr, inst_valid, inst, inst_pc, count
    );

    // Memory / decode environment side
    modport slave (
        output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the PC, issues pipelined imem requests under a credit
// limit, buffers responses in a prefetch FIFO and flushes everything on redirect.
module fetch_queue #(
    parameter int unsigned         PC_WIDTH = 8,
    parameter int unsigned         DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);
    localparam logic [CW:0]   DepthW = (CW + 1)'(DEPTH);

    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]       outstanding_q, outstanding_d;
    logic [CW-1:0]       drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]       count_q, count_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [31:0]         inst_mem_q [DEPTH];
    logic [PC_WIDTH-1:0] pc_mem_q   [DEPTH];

    logic                grant;
    logic                push;
    logic                pop;
    logic [CW:0]         credits_used;
    logic [PC_WIDTH-1:0] redirect_aligned;

    // Request credit, handshake qualifiers and FIFO head outputs
    always_comb begin
        credits_used     = {1'b0, outstanding_q} + {1'b0, count_q};
        redirect_aligned = {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};
        bus.imem_req     = !rst && !bus.redirect && (credits_used < DepthW);
        bus.imem_addr    = fetch_pc_q;
        grant            = bus.imem_req && bus.imem_gnt;
        bus.inst_valid   = (count_q != '0);
        bus.inst         = inst_mem_q[rd_ptr_q];
        bus.inst_pc      = pc_mem_q[rd_ptr_q];
        bus.count        = count_q;
        // Redirect swallows any response or pop in its own cycle
        push             = bus.imem_rvalid && (drop_cnt_q == '0) && !bus.redirect;
        pop              = bus.inst_valid && bus.inst_ready && !bus.redirect;
    end

    // Next-state for PCs, in-flight accounting and FIFO pointers
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        outstanding_d = outstanding_q + CW'(grant) - CW'(bus.imem_rvalid);

        if (bus.redirect) begin
            fetch_pc_d = redirect_aligned;
            resp_pc_d  = redirect_aligned;
            // Every request already granted must have its response discarded; a response
            // arriving right now is consumed here regardless.
            drop_cnt_d = outstanding_q - CW'(bus.imem_rvalid);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
            end
            if (bus.imem_rvalid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + PC_WIDTH'(4);
                wr_ptr_d  = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // FIFO storage; reset contents so the head reads {0, RESET_PC} out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= RESET_PC;
            end
        end else if (push) begin
            inst_mem_q[wr_ptr_q] <= bus.imem_rdata;
            pc_mem_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

    // The credit rule keeps a free slot for every in-flight response
    push_not_full: assert property (@(posedge clk) disable iff (rst) push |-> (count_q < DepthC));
    credit_bound:  assert property (@(posedge clk) disable iff (rst) credits_used <= DepthW);

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   wrap_done = 1'b0;

    always #5 clk = ~clk;

    fetch_queue_if #(.PC_WIDTH(8), .DEPTH(4)) bus ();
    fetch_queue_if #(.PC_WIDTH(8), .DEPTH(4)) wbus ();

    fetch_queue #(.PC_WIDTH(8), .DEPTH(4), .RESET_PC(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_queue #(.PC_WIDTH(8), .DEPTH(4), .RESET_PC(8'hF8)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (wbus)
    );

    function automatic logic [31:0] word_of(input logic [7:0] a);
        return {8'hC0, 8'h5A, a, ~a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        redir;
        logic [7:0]  rpc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        req;
        logic [7:0]  addr;
        logic        iv;
        logic [7:0]  ipc;
        logic [31:0] inst;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic redir, input logic [7:0] rpc, input logic gnt, input logic rv,
                       input logic [31:0] rdata, input logic rdy, input logic req,
                       input logic [7:0] addr, input logic iv, input logic [7:0] ipc,
                       input logic [31:0] inst, input logic [2:0] cnt);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy;
        v.req = req; v.addr = addr; v.iv = iv; v.ipc = ipc; v.inst = inst; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    // Wrap-around stream on the second instance: L=1 memory, always granting and consuming
    initial begin
        logic       prev_grant;
        logic [7:0] prev_addr;
        logic [7:0] exp_pc;
        wbus.redirect    = 1'b0;
        wbus.redirect_pc = '0;
        wbus.imem_gnt    = 1'b1;
        wbus.imem_rvalid = 1'b0;
        wbus.imem_rdata  = '0;
        wbus.inst_ready  = 1'b1;
        prev_grant = 1'b0;
        prev_addr  = '0;
        wait (rst == 1'b0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            wbus.imem_rvalid = prev_grant;
            wbus.imem_rdata  = word_of(prev_addr);
            #1;
            check($sformatf("wrap_valid_c%0d", k), {31'b0, wbus.inst_valid}, {31'b0, k >= 2});
            if (k >= 2) begin
                exp_pc = 8'hF8 + 8'(4 * (k - 2));
                check($sformatf("wrap_pc_c%0d", k), {24'b0, wbus.inst_pc}, {24'b0, exp_pc});
                check($sformatf("wrap_inst_c%0d", k), wbus.inst, word_of(exp_pc));
            end
            prev_grant = wbus.imem_req && wbus.imem_gnt;
            prev_addr  = wbus.imem_addr;
        end
        @(negedge clk);
        wbus.imem_rvalid = 1'b0;
        wbus.imem_gnt    = 1'b0;
        wrap_done = 1'b1;
    end

    typedef struct {
        logic [7:0] addr;
        int         due;
    } pend_t;

    initial begin
        pend_t      mq[$];
        pend_t      p;
        logic [7:0] exp_fetch;
        logic [7:0] exp_pop;
        int         cyc;
        int         pops;
        int         lat;

        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.inst_ready  = 1'b0;

        // Directed table: L=1 fill/backpressure/drain, redirect with two in flight,
        // redirect coinciding with rvalid and pop, back-to-back redirects.
        add(0, 8'h00, 1, 0, 32'h0,         0, 1, 8'h00, 0, 8'h00, 32'h0,         3'd0);
        add(0, 8'h00, 1, 1, 32'hA000_0000, 0, 1, 8'h04, 0, 8'h00, 32'h0,         3'd0);
        add(0, 8'h00, 1, 1, 32'hA000_0001, 0, 1, 8'h08, 1, 8'h00, 32'hA000_0000, 3'd1);
        add(0, 8'h00, 1, 1, 32'hA000_0002, 0, 1, 8'h0C, 1, 8'h00, 32'hA000_0000, 3'd2);
        add(0, 8'h00, 1, 1, 32'hA000_0003, 0, 0, 8'h10, 1, 8'h00, 32'hA000_0000, 3'd3);
        add(0, 8'h00, 1, 0, 32'h0,         0, 0, 8'h10, 1, 8'h00, 32'hA000_0000, 3'd4);
        add(0, 8'h00, 0, 0, 32'h0,         1, 0, 8'h10, 1, 8'h00, 32'hA000_0000, 3'd4);
        add(0, 8'h00, 1, 0, 32'h0,         1, 1, 8'h10, 1, 8'h04, 32'hA000_0001, 3'd3);
        add(0, 8'h00, 0, 1, 32'hA000_0004, 1, 1, 8'h14, 1, 8'h08, 32'hA000_0002, 3'd2);
        add(0, 8'h00, 0, 0, 32'h0,         1, 1, 8'h14, 1, 8'h0C, 32'hA000_0003, 3'd2);
        add(0, 8'h00, 0, 0, 32'h0,         1, 1, 8'h14, 1, 8'h10, 32'hA000_0004, 3'd1);
        add(0, 8'h00, 1, 0, 32'h0,         0, 1, 8'h14, 0, 8'h00, 32'h0,         3'd0);
        add(0, 8'h00, 1, 0, 32'h0,         0, 1, 8'h18, 0, 8'h00, 32'h0,         3'd0);
        add(1, 8'h41, 1, 0, 32'h0,         0, 0, 8'h1C, 0, 8'h00, 32'h0,         3'd0);
        add(0, 8'h00, 1, 0, 32'h0,         0, 1, 8'h40, 0, 8'h00, 32'h0,         3'd0);
        add(0, 8'h00, 0, 1, 32'hDEAD_0001, 0, 1, 8'h44, 0, 8'h00, 32'h0,         3'd0);
        add(0, 8'h00, 0, 1, 32'hDEAD_0002, 0, 1, 8'h44, 0, 8'h00, 32'h0,         3'd0);
        add(0, 8'h00, 0, 1, 32'hA000_0005, 0, 1, 8'h44, 0, 8'h00, 32'h0,         3'd0);
        add(0, 8'h00, 1, 0, 32'h0,         0, 1, 8'h44, 1, 8'h40, 32'hA000_0005, 3'd1);
        add(0, 8'h00, 1, 0, 32'h0,         0, 1, 8'h48, 1, 8'h40, 32'hA000_0005, 3'd1);
        add(0, 8'h00, 1, 0, 32'h0,         0, 1, 8'h4C, 1, 8'h40, 32'hA000_0005, 3'd1);
        add(1, 8'h80, 0, 1, 32'hDEAD_0003, 1, 0, 8'h50, 1, 8'h40, 32'hA000_0005, 3'd1);
        add(0, 8'h00, 0, 0, 32'h0,         1, 1, 8'h80, 0, 8'h00, 32'h0,         3'd0);
        add(0, 8'h00, 0, 1, 32'hDEAD_0004, 1, 1, 8'h80, 0, 8'h00, 32'h0,         3'd0);
        add(0, 8'h00, 0, 1, 32'hDEAD_0005, 1, 1, 8'h80, 0, 8'h00, 32'h0,         3'd0);
        add(0, 8'h00, 1, 0, 32'h0,         1, 1, 8'h80, 0, 8'h00, 32'h0,         3'd0);
        add(0, 8'h00, 0, 1, 32'hA000_0006, 1, 1, 8'h84, 0, 8'h00, 32'h0,         3'd0);
        add(0, 8'h00, 0, 0, 32'h0,         1, 1, 8'h84, 1, 8'h80, 32'hA000_0006, 3'd1);
        add(1, 8'h10, 0, 0, 32'h0,         1, 0, 8'h84, 0, 8'h00, 32'h0,         3'd0);
        add(1, 8'h22, 1, 0, 32'h0,         1, 0, 8'h10, 0, 8'h00, 32'h0,         3'd0);
        add(0, 8'h00, 1, 0, 32'h0,         1, 1, 8'h20, 0, 8'h00, 32'h0,         3'd0);
        add(0, 8'h00, 0, 1, 32'hA000_0007, 1, 1, 8'h24, 0, 8'h00, 32'h0,         3'd0);
        add(0, 8'h00, 0, 0, 32'h0,         0, 1, 8'h24, 1, 8'h20, 32'hA000_0007, 3'd1);

        // Reset state
        @(negedge clk);
        #1;
        check("rst_req",   {31'b0, bus.imem_req},   32'd0);
        check("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("rst_count", {29'b0, bus.count},      32'd0);
        check("rst_addr",  {24'b0, bus.imem_addr},  32'd0);
        check("rst_inst",  bus.inst,                32'd0);
        check("rst_pc",    {24'b0, bus.inst_pc},    32'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            if (i == 0) rst = 1'b0;
            bus.redirect    = vecs[i].redir;
            bus.redirect_pc = vecs[i].rpc;
            bus.imem_gnt    = vecs[i].gnt;
            bus.imem_rvalid = vecs[i].rv;
            bus.imem_rdata  = vecs[i].rdata;
            bus.inst_ready  = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d_req", i),   {31'b0, bus.imem_req},   {31'b0, vecs[i].req});
            check($sformatf("vec%0d_addr", i),  {24'b0, bus.imem_addr},  {24'b0, vecs[i].addr});
            check($sformatf("vec%0d_valid", i), {31'b0, bus.inst_valid}, {31'b0, vecs[i].iv});
            check($sformatf("vec%0d_count", i), {29'b0, bus.count},      {29'b0, vecs[i].cnt});
            if (vecs[i].iv) begin
                check($sformatf("vec%0d_pc", i),   {24'b0, bus.inst_pc}, {24'b0, vecs[i].ipc});
                check($sformatf("vec%0d_inst", i), bus.inst,             vecs[i].inst);
            end
        end

        // Random gnt/ready/redirects with an in-order memory of latency 1..3; the reference
        // is the stream view: grants and delivered instructions both walk +4 from the last
        // redirect target, with data a fixed function of the address.
        cyc = 0;
        pops = 0;
        exp_fetch = '0;
        exp_pop = '0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            bus.imem_rvalid = (mq.size() > 0) && (mq[0].due <= cyc);
            bus.imem_rdata  = bus.imem_rvalid ? word_of(mq[0].addr) : $urandom;
            bus.redirect    = (i == 0) || ($urandom_range(0, 39) == 0);
            bus.redirect_pc = 8'($urandom);
            bus.imem_gnt    = ($urandom_range(0, 3) != 0);
            bus.inst_ready  = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.redirect) begin
                check("rnd_req_in_redirect", {31'b0, bus.imem_req}, 32'd0);
                exp_fetch = bus.redirect_pc & 8'hFC;
                exp_pop   = bus.redirect_pc & 8'hFC;
            end else begin
                if (bus.imem_req && bus.imem_gnt) begin
                    check("rnd_grant_addr", {24'b0, bus.imem_addr}, {24'b0, exp_fetch});
                    lat = $urandom_range(1, 3);
                    p.addr = bus.imem_addr;
                    p.due  = cyc + lat;
                    if (mq.size() > 0 && mq[$].due >= p.due) p.due = mq[$].due + 1;
                    mq.push_back(p);
                    exp_fetch = exp_fetch + 8'd4;
                end
                if (bus.inst_valid && bus.inst_ready) begin
                    check("rnd_pop_pc",   {24'b0, bus.inst_pc}, {24'b0, exp_pop});
                    check("rnd_pop_inst", bus.inst,             word_of(exp_pop));
                    exp_pop = exp_pop + 8'd4;
                    pops++;
                end
            end
            check("rnd_count_bound", {31'b0, bus.count > 3'd4}, 32'd0);
            if (bus.imem_rvalid) void'(mq.pop_front());
            cyc++;
        end
        check("rnd_progress", {31'b0, pops > 200}, 32'd1);
        check("wrap_finished", {31'b0, wrap_done}, 32'd1);

        // Asynchronous mid-operation reset takes effect without a clock edge
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_req",   {31'b0, bus.imem_req},   32'd0);
        check("arst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("arst_count", {29'b0, bus.count},      32'd0);
        check("arst_addr",  {24'b0, bus.imem_addr},  32'd0);
        check("arst_inst",  bus.inst,                32'd0);
        check("arst_pc",    {24'b0, bus.inst_pc},    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
